// File: rtl/chacha_mem_pkg.sv
`timescale 1ns/1ps
// Shared constants and types for the ChaCha20 data-memory word reader.
package chacha_mem_pkg;

  // Byte address width of the 16K x 8 on-chip data memory.
  localparam int ADDR_W         = 14;
  localparam int BYTE_W         = 8;
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = WORD_W / BYTE_W;

  // Transfer sequencing: fetch bytes, then wait for the consumer to drain.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/chacha_word_fifo.sv
`timescale 1ns/1ps
// Small synchronous first-word-fall-through FIFO for packed words.
// The head entry is visible on pop_data whenever empty is low.
module chacha_word_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   cnt;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO can still accept a word when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  // Storage array: written at the tail on every accepted push.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the array is cleared on reset so the visible head word reads 0
      // after reset; it is only DEPTH entries, so this is flops, not a RAM.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_push) begin
      // NOTE: every clocked assignment uses <= so all flops update together
      // from pre-edge values, independent of statement order.
      mem[wr_ptr] <= push_data;
    end
  end

  // Head/tail pointers and occupancy count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (PTR_W+1)'(1);
        2'b01:   cnt <= cnt - (PTR_W+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign pop_data = mem[rd_ptr];
  assign count    = cnt;

endmodule

// File: rtl/chacha_mem_word_reader.sv
`timescale 1ns/1ps
// Avalon-MM read master: fetches 4*num_words bytes from the 8-bit data
// memory, packs them little-endian into 32-bit words and streams them to the
// ChaCha20 core over a valid/ready interface with a last-word marker.
module chacha_mem_word_reader
  import chacha_mem_pkg::*;
#(
  parameter int NWORDS_W   = 13,
  parameter int MAX_OUT    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [NWORDS_W-1:0] num_words,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_read,
  input  logic                avm_waitrequest,
  input  logic [7:0]          avm_readdata,
  input  logic                avm_readdatavalid,
  output logic [31:0]         word_data,
  output logic                word_valid,
  input  logic                word_ready,
  output logic                word_last
);

  localparam int BYTES_W  = NWORDS_W + 2;
  localparam int OUT_W    = $clog2(MAX_OUT + 1);
  localparam int FCNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int BUF_W    = BYTE_W * (BYTES_PER_WORD - 1);
  localparam int CREDIT_W = $clog2(MAX_OUT + BYTES_PER_WORD * (FIFO_DEPTH + 1));
  localparam int CREDIT_LIMIT = BYTES_PER_WORD * FIFO_DEPTH;

  state_t                state;
  state_t                state_nxt;

  logic [ADDR_W-1:0]     req_addr;
  logic [BYTES_W-1:0]    req_left;
  logic [NWORDS_W-1:0]   last_word_idx;
  logic [NWORDS_W-1:0]   word_idx;
  logic [OUT_W-1:0]      outstanding;
  logic [1:0]            pack_cnt;
  logic [BUF_W-1:0]      pack_buf;
  logic                  done_q;

  logic                  start_xfer;
  logic                  start_empty;
  logic                  issue_ok;
  logic                  req_accept;
  logic                  byte_valid;
  logic                  last_hs;
  logic                  credit_ok;
  logic [CREDIT_W-1:0]   committed;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_empty;
  logic [FCNT_W-1:0]     fifo_cnt;
  logic [WORD_W:0]       fifo_din;
  logic [WORD_W:0]       fifo_dout;

  // start is honoured only in IDLE; a zero-length request just pulses done.
  assign start_xfer  = (state == IDLE) && start && (num_words != '0);
  assign start_empty = (state == IDLE) && start && (num_words == '0);

  // Bytes already promised to the output path: in flight, half-packed, or
  // sitting in the FIFO as whole words. Keeping this below the FIFO capacity
  // guarantees every returned byte has somewhere to go.
  assign committed = CREDIT_W'(outstanding)
                   + CREDIT_W'(pack_cnt)
                   + CREDIT_W'({fifo_cnt, 2'b00});
  assign credit_ok = (committed < CREDIT_W'(CREDIT_LIMIT));

  assign issue_ok   = (state == FETCH) && (req_left != '0)
                   && (outstanding < OUT_W'(MAX_OUT)) && credit_ok;
  assign req_accept = issue_ok && !avm_waitrequest;

  // Returned data with nothing outstanding is a protocol error and is dropped.
  assign byte_valid = avm_readdatavalid && (outstanding != '0);

  assign last_hs = word_valid && word_ready && word_last;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and read-request decode.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    state_nxt = state;
    avm_read  = 1'b0;
    case (state)
      IDLE: begin
        if (start_xfer) begin
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        avm_read = issue_ok;
        if (req_accept && (req_left == BYTES_W'(1))) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (last_hs) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Request address and remaining-byte counter; address holds while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_addr      <= '0;
      req_left      <= '0;
      last_word_idx <= '0;
    end else if (start_xfer) begin
      req_addr      <= base_addr;
      req_left      <= {num_words, 2'b00};
      last_word_idx <= num_words - NWORDS_W'(1);
    end else if (req_accept) begin
      req_addr <= req_addr + ADDR_W'(1);
      req_left <= req_left - BYTES_W'(1);
    end
  end

  // Reads accepted by the memory but not yet answered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outstanding <= '0;
    end else begin
      case ({req_accept, byte_valid})
        2'b10:   outstanding <= outstanding + OUT_W'(1);
        2'b01:   outstanding <= outstanding - OUT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Byte packer: bytes 0..2 are buffered, byte 3 completes the word directly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pack_cnt <= '0;
      pack_buf <= '0;
      word_idx <= '0;
    end else if (start_xfer) begin
      pack_cnt <= '0;
      word_idx <= '0;
    end else if (byte_valid) begin
      if (pack_cnt == 2'd3) begin
        pack_cnt <= '0;
        word_idx <= word_idx + NWORDS_W'(1);
      end else begin
        pack_cnt <= pack_cnt + 2'd1;
        pack_buf[{pack_cnt, 3'b000} +: BYTE_W] <= avm_readdata;
      end
    end
  end

  assign fifo_push = byte_valid && (pack_cnt == 2'd3);
  assign fifo_din  = {(word_idx == last_word_idx), avm_readdata, pack_buf};
  assign fifo_pop  = word_valid && word_ready;

  chacha_word_fifo #(
    .WIDTH (WORD_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data (fifo_din),
    .pop       (fifo_pop),
    .pop_data  (fifo_dout),
    .count     (fifo_cnt),
    .empty     (fifo_empty)
  );

  // done pulses the cycle after a zero-length start or the final handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_q <= 1'b0;
    end else begin
      done_q <= start_empty || ((state == DRAIN) && last_hs);
    end
  end

  assign busy        = (state != IDLE);
  assign done        = done_q;
  assign avm_address = req_addr;
  assign word_valid  = !fifo_empty;
  assign word_data   = fifo_dout[WORD_W-1:0];
  assign word_last   = fifo_dout[WORD_W];

endmodule

// File: tb/tb_chacha_mem_word_reader.sv
`timescale 1ns/1ps
// Directed bench for chacha_mem_word_reader with a latency-1 byte memory model.
module tb_chacha_mem_word_reader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [13:0] base_addr = '0;
  logic [12:0] num_words = '0;
  logic        busy;
  logic        done;
  logic [13:0] avm_address;
  logic        avm_read;
  logic        avm_waitrequest = 1'b0;
  logic [7:0]  avm_readdata = '0;
  logic        avm_readdatavalid = 1'b0;
  logic [31:0] word_data;
  logic        word_valid;
  logic        word_ready = 1'b1;
  logic        word_last;

  always #5 clk = ~clk;

  chacha_mem_word_reader dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start             (start),
    .base_addr         (base_addr),
    .num_words         (num_words),
    .busy              (busy),
    .done              (done),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .word_data         (word_data),
    .word_valid        (word_valid),
    .word_ready        (word_ready),
    .word_last         (word_last)
  );

  logic [7:0]  mem [16384];
  logic [32:0] got_q [$];
  logic [13:0] addr_q [$];
  int          errors = 0;
  int          checks = 0;
  int          rdv_cnt = 0;
  int          rd_cycles = 0;
  logic        wr_rand = 1'b0;
  logic        pending = 1'b0;
  logic [13:0] pending_addr = '0;
  logic        prev_stall = 1'b0;
  logic [13:0] prev_addr = '0;

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Memory model and stream monitor, evaluated on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        pending           = 1'b0;
        prev_stall        = 1'b0;
        avm_readdatavalid = 1'b0;
        avm_waitrequest   = 1'b0;
      end else begin
        if (prev_stall) begin
          check("wr_hold_read", 64'(avm_read), 64'd1);
          check("wr_hold_addr", 64'(avm_address), 64'(prev_addr));
        end
        if (word_valid && word_ready) got_q.push_back({word_last, word_data});
        if (avm_read) rd_cycles++;
        avm_readdatavalid = pending;
        avm_readdata      = pending ? mem[pending_addr] : 8'h00;
        if (pending) rdv_cnt++;
        avm_waitrequest = wr_rand ? 1'($urandom_range(0, 1)) : 1'b0;
        pending = avm_read && !avm_waitrequest;
        if (pending) begin
          pending_addr = avm_address;
          addr_q.push_back(avm_address);
        end
        prev_stall = avm_read && avm_waitrequest;
        prev_addr  = avm_address;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    got_q.delete();
    addr_q.delete();
    rdv_cnt   = 0;
    rd_cycles = 0;
  endtask

  task automatic pulse_start(input logic [13:0] b, input logic [12:0] n);
    base_addr = b;
    num_words = n;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // Called in the cycle after start; counts cycles from the start cycle (0).
  task automatic wait_done(input string tag, input int budget,
                           output int cycles, output int first_valid);
    logic prev_hs;
    prev_hs     = 1'b0;
    cycles      = 1;
    first_valid = -1;
    while (done !== 1'b1 && cycles < budget) begin
      if (word_valid === 1'b1 && first_valid < 0) first_valid = cycles;
      prev_hs = word_valid & word_ready & word_last;
      tick();
      cycles++;
    end
    check({tag, "_done_seen"}, 64'(done), 64'd1);
    check({tag, "_done_after_last"}, 64'(prev_hs), 64'd1);
    check({tag, "_busy_low"}, 64'(busy), 64'd0);
    tick();
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  task automatic check_words(input string tag, input logic [13:0] b, input int n);
    logic [13:0] a;
    logic [32:0] exp_w;
    check({tag, "_nwords"}, 64'(got_q.size()), 64'(n));
    for (int k = 0; k < n && k < got_q.size(); k++) begin
      a = b + 14'(4 * k);
      exp_w = {(k == n - 1), mem[a + 14'd3], mem[a + 14'd2], mem[a + 14'd1], mem[a]};
      check($sformatf("%s_word%0d", tag, k), 64'(got_q[k]), 64'(exp_w));
    end
  endtask

  task automatic check_addrs(input string tag, input logic [13:0] b, input int n);
    check({tag, "_nreads"}, 64'(addr_q.size()), 64'(n));
    for (int i = 0; i < n && i < addr_q.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), 64'(addr_q[i]), 64'(b + 14'(i)));
    end
  endtask

  initial begin
    int cyc;
    int fv;

    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
    for (int i = 0; i < 8; i++) mem[14'h0010 + 14'(i)] = 8'(i + 1);
    mem[14'h3FFE] = 8'hA1;
    mem[14'h3FFF] = 8'hB2;
    mem[14'h0000] = 8'hC3;
    mem[14'h0001] = 8'hD4;
    for (int i = 0; i < 64; i++) mem[14'h0100 + 14'(i)] = 8'(i);
    for (int i = 0; i < 32; i++) mem[14'h0200 + 14'(i)] = 8'(8'h80 + i);
    for (int i = 0; i < 32; i++) mem[14'h0300 + 14'(i)] = 8'(8'h40 + i);

    // Reset state
    repeat (3) tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_read", 64'(avm_read), 64'd0);
    check("rst_addr", 64'(avm_address), 64'd0);
    check("rst_valid", 64'(word_valid), 64'd0);
    check("rst_last", 64'(word_last), 64'd0);
    check("rst_data", 64'(word_data), 64'd0);
    reset_n = 1'b1;
    tick();

    // 1: two words from 0x10, latency and throughput
    clear_logs();
    pulse_start(14'h0010, 13'd2);
    check("t1_busy", 64'(busy), 64'd1);
    wait_done("t1", 100, cyc, fv);
    check("t1_latency", 64'(fv), 64'd6);
    check("t1_total_cycles", 64'(cyc), 64'd11);
    check("t1_nwords", 64'(got_q.size()), 64'd2);
    check("t1_word0", 64'(got_q[0]), 64'h0_0403_0201);
    check("t1_word1", 64'(got_q[1]), 64'h1_0807_0605);
    check_addrs("t1", 14'h0010, 8);

    // 2: address wrap 3FFE -> 0001
    clear_logs();
    pulse_start(14'h3FFE, 13'd1);
    wait_done("t2", 100, cyc, fv);
    check("t2_nwords", 64'(got_q.size()), 64'd1);
    check("t2_word0", 64'(got_q[0]), 64'h1_D4C3_B2A1);
    check("t2_nreads", 64'(addr_q.size()), 64'd4);
    check("t2_addr0", 64'(addr_q[0]), 64'h3FFE);
    check("t2_addr1", 64'(addr_q[1]), 64'h3FFF);
    check("t2_addr2", 64'(addr_q[2]), 64'h0000);
    check("t2_addr3", 64'(addr_q[3]), 64'h0001);

    // 3: consumer stalled, credit limits reads to 16 bytes
    clear_logs();
    word_ready = 1'b0;
    pulse_start(14'h0100, 13'd16);
    repeat (40) tick();
    check("t3_stall_reads", 64'(addr_q.size()), 64'd16);
    check("t3_stall_valid", 64'(word_valid), 64'd1);
    check("t3_stall_data", 64'(word_data), 64'h0302_0100);
    check("t3_stall_busy", 64'(busy), 64'd1);
    word_ready = 1'b1;
    wait_done("t3", 300, cyc, fv);
    check_words("t3", 14'h0100, 16);
    check_addrs("t3", 14'h0100, 64);

    // 4: random waitrequest
    clear_logs();
    wr_rand = 1'b1;
    pulse_start(14'h0200, 13'd8);
    wait_done("t4", 400, cyc, fv);
    wr_rand = 1'b0;
    check_words("t4", 14'h0200, 8);
    check_addrs("t4", 14'h0200, 32);

    // 5: zero-length request, then start while busy
    clear_logs();
    pulse_start(14'h0000, 13'd0);
    check("t5_zero_done", 64'(done), 64'd1);
    check("t5_zero_busy", 64'(busy), 64'd0);
    tick();
    check("t5_zero_done_pulse", 64'(done), 64'd0);
    repeat (4) tick();
    check("t5_zero_no_read", 64'(rd_cycles), 64'd0);
    pulse_start(14'h0010, 13'd2);
    tick();
    tick();
    pulse_start(14'h0300, 13'd5);
    wait_done("t5", 100, cyc, fv);
    check("t5_nwords", 64'(got_q.size()), 64'd2);
    check("t5_word0", 64'(got_q[0]), 64'h0_0403_0201);
    check("t5_word1", 64'(got_q[1]), 64'h1_0807_0605);
    check_addrs("t5", 14'h0010, 8);

    // 6: reset after five bytes, then a clean transfer
    clear_logs();
    pulse_start(14'h0300, 13'd8);
    cyc = 0;
    while (rdv_cnt < 5 && cyc < 50) begin
      tick();
      cyc++;
    end
    check("t6_five_bytes", 64'(rdv_cnt >= 5), 64'd1);
    reset_n = 1'b0;
    #1;
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_done", 64'(done), 64'd0);
    check("t6_rst_read", 64'(avm_read), 64'd0);
    check("t6_rst_addr", 64'(avm_address), 64'd0);
    check("t6_rst_valid", 64'(word_valid), 64'd0);
    check("t6_rst_last", 64'(word_last), 64'd0);
    check("t6_rst_data", 64'(word_data), 64'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    clear_logs();
    pulse_start(14'h0010, 13'd2);
    wait_done("t6", 100, cyc, fv);
    check("t6_nwords", 64'(got_q.size()), 64'd2);
    check("t6_word0", 64'(got_q[0]), 64'h0_0403_0201);
    check("t6_word1", 64'(got_q[1]), 64'h1_0807_0605);
    check_addrs("t6", 14'h0010, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
